// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the transmit packet scheduler and the packetizer
// that sits downstream of its payload FIFO.
package tx_sched_pkg;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_GRANT     = 5'b00010,
        ST_LOAD      = 5'b00100,
        ST_WAIT_SENT = 5'b01000,
        ST_GAP       = 5'b10000
    } state_e;

    localparam logic [1:0] MODE_BPSK = 2'd0;
    localparam logic [1:0] MODE_QPSK = 2'd1;
    localparam logic [1:0] MODE_MIX  = 2'd2;

    // QPSK carries two bits per symbol; an odd trailing bit is dropped.
    function automatic logic [15:0] symbs_from_len(input logic [15:0] len, input logic bpsk);
        return bpsk ? len : {1'b0, len[15:1]};
    endfunction

endpackage

// File: rtl/tx_packet_scheduler_arb.sv
// Two-requester round-robin arbiter; the pointer only moves once a granted
// packet has fully completed, so an aborted packet does not cost a turn.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       served_idx_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    // Reset value marks requester 1 as last served so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= served_idx_i;
        end
    end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Shares the transmit payload path between two requesters: one packet per grant,
// pass-through symbol streaming, pkt_sent handshake with timeout, and an idle gap.
module tx_packet_scheduler
    import tx_sched_pkg::*;
#(
    parameter int BYTES          = 1,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid_i,
    input  logic [15:0]          req0_len_i,
    input  logic                 req0_bpsk_i,
    output logic                 req0_ack_o,
    input  logic [BYTES*8-1:0]   s0_tdata_i,
    input  logic                 s0_tvalid_i,
    output logic                 s0_tready_o,
    input  logic                 req1_valid_i,
    input  logic [15:0]          req1_len_i,
    input  logic                 req1_bpsk_i,
    output logic                 req1_ack_o,
    input  logic [BYTES*8-1:0]   s1_tdata_i,
    input  logic                 s1_tvalid_i,
    output logic                 s1_tready_o,
    output logic [BYTES*8-1:0]   m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 m_tuser_o,
    output logic [15:0]          payload_length_o,
    input  logic                 pkt_sent_i,
    output logic [1:0]           grant_o,
    output logic                 busy_o,
    output logic                 timeout_err_o,
    output logic                 zero_len_err_o
);

    state_e      state_q;
    logic [1:0]  sel_q, grant_q, arb_gnt;
    logic        ack0_q, ack1_q, tuser_q, tmo_err_q, zero_err_q, sent_prev_q;
    logic [15:0] len_q, symbs_q, beat_cnt_q, gap_cnt_q, symbs_d;
    logic [31:0] tmo_cnt_q;
    logic        in_load, hs, last_beat, sent_edge, gap_done;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        ({req1_valid_i, req0_valid_i}),
        .upd_i        (state_q == ST_GAP && gap_done),
        .served_idx_i (grant_q[1]),
        .gnt_o        (arb_gnt)
    );

    assign in_load     = (state_q == ST_LOAD);
    assign m_tvalid_o  = in_load & (grant_q[1] ? s1_tvalid_i : s0_tvalid_i);
    assign m_tdata_o   = in_load ? (grant_q[1] ? s1_tdata_i : s0_tdata_i) : '0;
    assign s0_tready_o = in_load & grant_q[0] & m_tready_i;
    assign s1_tready_o = in_load & grant_q[1] & m_tready_i;
    assign last_beat   = (beat_cnt_q == symbs_q - 16'd1);
    assign m_tlast_o   = last_beat & m_tvalid_o;
    assign hs          = m_tvalid_o & m_tready_i;
    assign sent_edge   = pkt_sent_i & ~sent_prev_q;
    assign gap_done    = (gap_cnt_q == 16'(GAP_CYCLES - 1));
    assign symbs_d     = symbs_from_len(sel_q[1] ? req1_len_i : req0_len_i,
                                        sel_q[1] ? req1_bpsk_i : req0_bpsk_i);

    assign req0_ack_o       = ack0_q;
    assign req1_ack_o       = ack1_q;
    assign m_tuser_o        = tuser_q;
    assign payload_length_o = len_q;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign timeout_err_o    = tmo_err_q;
    assign zero_len_err_o   = zero_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'b00;
            grant_q     <= 2'b00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            tuser_q     <= 1'b1;
            tmo_err_q   <= 1'b0;
            zero_err_q  <= 1'b0;
            sent_prev_q <= 1'b0;
            len_q       <= 16'd0;
            symbs_q     <= 16'd0;
            beat_cnt_q  <= 16'd0;
            gap_cnt_q   <= 16'd0;
            tmo_cnt_q   <= 32'd0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            zero_err_q  <= 1'b0;
            // A level that is already high when WAIT_SENT is entered never forms an edge.
            sent_prev_q <= pkt_sent_i;
            case (state_q)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        sel_q   <= arb_gnt;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ack0_q     <= sel_q[0];
                    ack1_q     <= sel_q[1];
                    grant_q    <= sel_q;
                    len_q      <= sel_q[1] ? req1_len_i : req0_len_i;
                    tuser_q    <= sel_q[1] ? req1_bpsk_i : req0_bpsk_i;
                    symbs_q    <= symbs_d;
                    beat_cnt_q <= 16'd0;
                    gap_cnt_q  <= 16'd0;
                    if (symbs_d == 16'd0) begin
                        zero_err_q <= 1'b1;
                        state_q    <= ST_GAP;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        beat_cnt_q <= beat_cnt_q + 16'd1;
                        if (last_beat) begin
                            tmo_cnt_q <= 32'd0;
                            state_q   <= ST_WAIT_SENT;
                        end
                    end
                end
                ST_WAIT_SENT: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    if (sent_edge) begin
                        gap_cnt_q <= 16'd0;
                        state_q   <= ST_GAP;
                    end else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        tmo_err_q <= 1'b1;
                        gap_cnt_q <= 16'd0;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 16'd1;
                    if (gap_done) begin
                        grant_q <= 2'b00;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_packet_scheduler.md
Name: tx_packet_scheduler

Overview:
- Sits upstream of the payload FIFO that feeds the transmit packetizer; shares that single transmit path between two payload sources (requesters).
- Grants one requester per packet (round-robin), latches its length/modulation, streams exactly one packet of symbols with tlast/tuser, then waits for the packetizer's pkt_sent before allowing the next packet.
- Enforces a minimum idle gap between packets and recovers from a lost pkt_sent via timeout.

Parameters:
BYTES, 1, AXIS data width in bytes (BITS = BYTES*8); matches the packetizer.
GAP_CYCLES, 16, idle clk cycles after a packet completes before the next grant; range 1..65535.
TIMEOUT_CYCLES, 4096, max clk cycles spent in WAIT_SENT before the timeout error.

Ports:
clk  in  1  symbol-rate clock (1.024 MHz domain)
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
req0_valid  in  1  requester 0 has a packet pending; held until req0_ack
req0_len  in  16  requester 0 payload length in bits
req0_bpsk  in  1  requester 0 modulation: 1 BPSK, 0 QPSK
req0_ack  out  1  one-cycle grant pulse to requester 0
s0_tdata  in  BITS  requester 0 symbol stream
s0_tvalid  in  1  requester 0 AXIS valid
s0_tready  out  1  requester 0 AXIS ready
req1_valid, req1_len, req1_bpsk, req1_ack, s1_tdata, s1_tvalid, s1_tready: same as requester 0
m_tdata  out  BITS  to payload FIFO
m_tvalid  out  1  AXIS valid to FIFO
m_tready  in  1  FIFO not full
m_tlast  out  1  last payload symbol
m_tuser  out  1  is_bpsk of the current packet
payload_length  out  16  latched bit length for the packetizer; stable from grant until the next grant
pkt_sent  in  1  packetizer level flag: packet fully sent and FIFO drained
grant  out  2  one-hot active requester; 00 when none
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on WAIT_SENT timeout
zero_len_err  out  1  one-cycle pulse when a granted packet has 0 symbols

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, except m_tuser=1; rr pointer favours requester 0; counters cleared. Reset mid-packet drops the packet; s*_tready go to 0 immediately.
- symbs = bpsk ? len : len>>1, 16-bit unsigned. Odd QPSK bit length truncates (len=5 QPSK gives 2 symbols).
- IDLE: if any reqX_valid, go to GRANT on the next edge.
- GRANT (1 cycle):
  - Round-robin: if both requesters are valid, pick the one not served last; otherwise pick the single valid one. Decision is sampled in IDLE.
  - Pulse reqX_ack; latch payload_length, m_tuser and symbs; set grant; clear beat_cnt.
  - If symbs==0: pulse zero_len_err and go to GAP. Otherwise go to LOAD.
  - If a requester drops req before the IDLE sample, it is not granted.
- LOAD:
  - Combinational pass-through of the granted source: m_tdata/m_tvalid = sX, sX_tready = m_tready. The non-granted sY_tready = 0.
  - beat_cnt increments on m_tvalid & m_tready.
  - m_tlast = (beat_cnt == symbs-1) & m_tvalid.
  - On the handshake of the tlast beat, go to WAIT_SENT. After that, sX_tready = 0 and m_tvalid = 0.
  - Outside LOAD, m_tvalid = 0 and m_tlast = 0.
- WAIT_SENT:
  - Detect a pkt_sent rising edge using pkt_sent registered once on entry, so a stale high level from the previous packet is ignored. On the edge, go to GAP.
  - tmo_cnt counts every cycle; at TIMEOUT_CYCLES-1, pulse timeout_err and go to GAP.
  - If the edge and the timeout coincide, the edge wins and timeout_err is not pulsed.
- GAP: gap_cnt runs 0..GAP_CYCLES-1; then clear grant, update the rr pointer, go to IDLE.
- Requests arriving while busy are held off; the requester keeps reqX_valid asserted. Inputs reqX_len and reqX_bpsk are sampled only in GRANT.
- Latency: reqX_valid to reqX_ack is 2 cycles; zero added latency on the data path.

Decomposition:
- Package tx_sched_pkg:
  - state localparams, one-hot 5-bit: IDLE, GRANT, LOAD, WAIT_SENT, GAP
  - MODE_BPSK / MODE_QPSK / MODE_MIX constants shared with the packetizer
  - function symbs_from_len(len, bpsk)
- Sub-module: rr_arbiter2 (2-requester round-robin with a pointer updated on grant completion).
- Datapath mux and FSM stay in the top module.

Test Plan:
- req0 only, len=8, BPSK, m_tready=1, pkt_sent rises 50 cycles after tlast -> ack at cycle 2; 8 beats; tlast on beat 8; m_tuser=1; payload_length=8; next grant no earlier than GAP_CYCLES after the pkt_sent edge.
- req0 and req1 both valid continuously, len=4 each -> grants alternate 01,10,01,10; each ack is exactly one pulse per packet.
- req1 QPSK len=7 with m_tready toggling 1010 -> exactly 3 beats accepted; tlast coincides with the 3rd handshake; no data lost or duplicated.
- req0 len=0 (and QPSK len=1) -> zero_len_err pulse, no m_tvalid, scheduler returns to IDLE after the gap.
- pkt_sent held high from the previous packet and never re-rises -> timeout_err pulse exactly TIMEOUT_CYCLES after WAIT_SENT entry; then GAP, then IDLE.
- rst_n asserted mid-LOAD at beat 3 of 10 -> outputs cleared asynchronously; after release, the next request is granted fresh starting with requester 0.
